dma_peripheral_port: RTL

Peripheral-side endpoint of the DREQ/DACK DMA handshake: the block a peripheral (MDEC, SPU, GPU, CDROM, PIO) instantiates to talk to one DMA controller channel. It buffers words in a FIFO and raises DREQ when a full block can be moved. It then accepts or supplies one 32-bit word per DACK cycle until the block completes. The peripheral core sees a plain valid/ready stream on the other side.

---
 rtl/dma_port_pkg.sv | 22 ++
 rtl/dma_port_fifo.sv | 80 ++++++++
 rtl/dma_peripheral_port.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dma_port_pkg.sv
// Shared types for the DREQ/DACK peripheral DMA port.
package dma_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } EPORTSTATE;

    typedef enum logic {
        TO_PERIPH   = 1'b0,
        FROM_PERIPH = 1'b1
    } EPORTDIR;

    localparam int unsigned DATA_W = 32;

    function automatic logic is_active(input EPORTSTATE s);
        return (s == REQ) || (s == BURST);
    endfunction

endpackage

// File: rtl/dma_port_fifo.sv
// Synchronous FIFO with a registered show-ahead head word, flush and level output.
module dma_port_fifo
    import dma_port_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = i_pop && (level_q != '0) && !i_flush;
        do_push  = i_push && ((level_q != FULL_LVL) || do_pop) && !i_flush;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Head bypasses memory when the pushed word becomes the only entry.
        head_d = head_q;
        if (do_push && ((level_q == '0) || (do_pop && (level_q == LW'(1))))) begin
            head_d = i_push_data;
        end else if (do_pop && (level_d != '0)) begin
            head_d = mem_q[rd_ptr_d];
        end

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            head_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    assign o_head  = head_q;
    assign o_level = level_q;

endmodule

// File: rtl/dma_peripheral_port.sv
// Peripheral endpoint of a DREQ/DACK DMA channel: FIFO, block FSM, direction latch.
// Optional stray-DACK error flag enabled by defining DMA_PORT_ERR_EN.
module dma_peripheral_port
    import dma_port_pkg::*;
#(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned BLOCK_WORDS = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_dir,
    input  logic                       i_flush,
    output logic                       o_dreq,
    input  logic                       i_dack,
    input  logic [31:0]                i_dma_data,
    output logic [31:0]                o_dma_data,
    output logic                       o_per_valid,
    output logic [31:0]                o_per_data,
    input  logic                       i_per_ready,
    input  logic                       i_per_valid,
    input  logic [31:0]                i_per_data,
    output logic                       o_per_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_busy,
    output logic                       o_err_stray
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(BLOCK_WORDS + 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] BLOCK_LVL = LW'(BLOCK_WORDS);
    localparam logic [LW-1:0] ROOM_MAX  = LW'(DEPTH - BLOCK_WORDS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_WORDS);

    EPORTSTATE       state_q, state_d;
    EPORTDIR         dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dreq_q, dreq_d;

    logic            active, beat, push, pop, thresh;
    logic [31:0]     push_data, head;
    logic [LW-1:0]   level;

    dma_port_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_push      (push),
        .i_push_data (push_data),
        .i_pop       (pop),
        .o_head      (head),
        .o_level     (level)
    );

    always_comb begin
        active      = is_active(state_q);
        beat        = i_dack && active && !i_flush;
        o_per_valid = (dir_q == TO_PERIPH) && (level != '0);
        o_per_ready = (dir_q == FROM_PERIPH) && (level != FULL_LVL);
        if (dir_q == TO_PERIPH) begin
            push      = beat;
            push_data = i_dma_data;
            pop       = o_per_valid && i_per_ready;
            thresh    = level <= ROOM_MAX;
        end else begin
            push      = i_per_valid && o_per_ready;
            push_data = i_per_data;
            pop       = beat;
            thresh    = level >= BLOCK_LVL;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (state_q == IDLE) begin
            dir_d = EPORTDIR'(i_dir);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_enable && thresh) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_dack) begin
                    if (CW'(1) == LAST_BEAT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = BURST;
                        cnt_d   = CW'(1);
                    end
                end else if (!i_enable) begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (i_dack) begin
                    if (cnt_q + CW'(1) == LAST_BEAT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // DREQ is a flop of the next state so it never glitches on decode.
        dreq_d = is_active(state_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= TO_PERIPH;
            dreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dreq_q  <= dreq_d;
        end
    end

`ifdef DMA_PORT_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (i_dack && !active);
        if (i_flush) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err_stray = err_q;
`else
    assign o_err_stray = 1'b0;
`endif

    assign o_dreq     = dreq_q;
    assign o_busy     = state_q != IDLE;
    assign o_level    = level;
    assign o_dma_data = head;
    assign o_per_data = head;

endmodule
